// File: rtl/rr_select_arbiter_pkg.sv
// Shared types and sizes for the round-robin select arbiter and its priority picker.
// No logic here; latency and backpressure are defined by the modules that import it.
package rr_select_arbiter_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Index after idx, wrapping naturally at the SEL_W boundary (3 -> 0).
    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
        return idx + SEL_W'(1);
    endfunction

endpackage

// File: rtl/rr_select_arbiter_pick.sv
// Combinational rotating-priority pick: first set request scanning from ptr upward, mod N_REQ.
// Zero latency, no backpressure; any_o is low when no request is set and winner_o is then meaningless.
module rr_priority_pick
    import rr_select_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic [SEL_W-1:0] winner_o,
    output logic             any_o
);

    logic [SEL_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest set bit is the last write.
    always_comb begin
        winner_o = ptr_i;
        any_o    = |req_i;
        idx      = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = ptr_i + SEL_W'(i);
            if (req_i[idx]) begin
                winner_o = idx;
            end
        end
    end

endmodule

// File: rtl/rr_select_arbiter.sv
// Round-robin arbiter driving the decoder select; grant registered one edge after req, held until done/drop/timeout.
// Holders release via done or by dropping req; one IDLE cycle always separates consecutive grants.
module rr_select_arbiter
    import rr_select_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [SEL_W-1:0] sel,
    output logic             sel_valid,
    output logic             busy,
    output logic             timeout
);

    localparam bit               HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    logic [SEL_W-1:0] pick_winner;
    logic             pick_any;
    logic             rel_by_req;
    logic             rel_by_to;
    logic             release_now;

    rr_priority_pick u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .winner_o (pick_winner),
        .any_o    (pick_any)
    );

    // A holder-initiated release (done or dropped request) takes precedence over the timeout.
    assign rel_by_req  = done | ~req[sel_q];
    assign rel_by_to   = HOLD_EN && (cnt_q == HOLD_LAST);
    assign release_now = rel_by_req | rel_by_to;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_any)    state_d = GRANT;
            GRANT:   if (release_now) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q     <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // sel is left untouched on release so the decoder input does not glitch while sel_valid is low.
    always_comb begin
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    sel_d = pick_winner;
                    cnt_d = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_d     = next_idx(sel_q);
                    timeout_d = rel_by_to & ~rel_by_req;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                sel_d = sel_q;
            end
        endcase
    end

    always_comb begin
        sel       = sel_q;
        sel_valid = (state_q == GRANT);
        busy      = (state_q == GRANT);
        timeout   = timeout_q;
    end

endmodule

// File: tb/tb_rr_select_arbiter.sv
// Randomised and directed bench for rr_select_arbiter against a cycle-level behavioural model.
module tb_rr_select_arbiter;

    localparam int MAX_HOLD = 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [1:0] sel;
    logic       sel_valid;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    // Behavioural model: who holds the grant, for how many cycles, and where the scan starts.
    bit m_grant;
    int m_sel;
    int m_ptr;
    int m_held;
    int m_to;

    rr_select_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .sel       (sel),
        .sel_valid (sel_valid),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1, "watchdog");
    end

    function automatic void model_update();
        bit by_req;
        bit by_to;
        if (!rst_n) begin
            m_grant = 0; m_sel = 0; m_ptr = 0; m_held = 0; m_to = 0;
        end else if (!m_grant) begin
            m_to = 0;
            if (req != 4'b0000) begin
                for (int k = 0; k < 4; k++) begin
                    if (req[(m_ptr + k) % 4]) begin
                        m_sel = (m_ptr + k) % 4;
                        break;
                    end
                end
                m_grant = 1;
                m_held  = 1;
            end
        end else begin
            by_req = done || !req[m_sel];
            by_to  = (MAX_HOLD != 0) && (m_held >= MAX_HOLD);
            m_to   = 0;
            if (by_req || by_to) begin
                m_grant = 0;
                m_ptr   = (m_sel + 1) % 4;
                m_to    = by_req ? 0 : 1;
            end else begin
                m_held++;
            end
        end
    endfunction

    function automatic logic [4:0] exp_vec();
        logic [1:0] s;
        s = m_sel[1:0];
        return {m_grant, m_grant, (m_to != 0), s};
    endfunction

    function automatic logic [4:0] obs_vec();
        return {sel_valid, busy, timeout, sel};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = 4'b0000; done = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs_vec() !== 5'b00000) begin
            errors++;
            $display("FAIL reset_outputs: got %b want %b", obs_vec(), 5'b00000);
        end
        req = 4'b0000; done = 1'b1;
        tick();
        checks++;
        if (obs_vec() !== exp_vec() || sel_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_done_ignored: got %b want %b", obs_vec(), exp_vec());
        end
        done = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001;
        tick();
        checks++;
        if (sel_valid !== 1'b1 || sel !== 2'd0 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL single_grant: got %b want %b", obs_vec(), exp_vec());
        end
        tick();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (sel_valid !== 1'b0 || timeout !== 1'b0 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL single_release: got %b want %b", obs_vec(), exp_vec());
        end
        req = 4'b0011;
        tick();
        checks++;
        if (sel !== 2'd1 || sel_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_ptr_next: got sel=%0d vld=%b want sel=1 vld=1", sel, sel_valid);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_rotate();
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (sel_valid !== 1'b1 || sel !== 2'(i % 4) || obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rotate_grant%0d: got sel=%0d vld=%b want sel=%0d vld=1", i, sel, sel_valid, i % 4);
            end
            done = 1'b1;
            tick();
            done = 1'b0;
            checks++;
            if (sel_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rotate_gap%0d: got vld=%b busy=%b want 0 0", i, sel_valid, busy);
            end
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_scan_wrap();
        do_reset();
        req = 4'b0100;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        req = 4'b0110;
        tick();
        checks++;
        if (sel !== 2'd1 || sel_valid !== 1'b1) begin
            errors++;
            $display("FAIL scan_wrap_first: got sel=%0d vld=%b want sel=1 vld=1", sel, sel_valid);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        checks++;
        if (sel !== 2'd2 || sel_valid !== 1'b1 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL scan_wrap_second: got sel=%0d vld=%b want sel=2 vld=1", sel, sel_valid);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        req = 4'b0100;
        tick();
        n = 0;
        while (sel_valid === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        checks++;
        if (n != MAX_HOLD) begin
            errors++;
            $display("FAIL timeout_hold_len: got %0d cycles want %0d", n, MAX_HOLD);
        end
        checks++;
        if (timeout !== 1'b1 || sel_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL timeout_pulse: got to=%b vld=%b want to=1 vld=0", timeout, sel_valid);
        end
        req = 4'b1100;
        tick();
        checks++;
        if (timeout !== 1'b0 || sel !== 2'd3 || sel_valid !== 1'b1) begin
            errors++;
            $display("FAIL timeout_after: got to=%b sel=%0d vld=%b want to=0 sel=3 vld=1", timeout, sel, sel_valid);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        req = 4'b0000;
        tick();
    endtask

    task automatic test_done_at_timeout();
        do_reset();
        req = 4'b0001;
        tick();
        repeat (MAX_HOLD - 1) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (sel_valid !== 1'b0 || timeout !== 1'b0 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL done_at_timeout: got vld=%b to=%b want vld=0 to=0", sel_valid, timeout);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL done_at_timeout_late: got to=%b want 0", timeout);
        end
    endtask

    task automatic test_drop_and_reset();
        do_reset();
        req = 4'b0100;
        tick();
        tick();
        req = 4'b1011;
        tick();
        checks++;
        if (sel_valid !== 1'b0 || timeout !== 1'b0 || sel !== 2'd2) begin
            errors++;
            $display("FAIL drop_release: got vld=%b to=%b sel=%0d want vld=0 to=0 sel=2", sel_valid, timeout, sel);
        end
        req = 4'b0100;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if (obs_vec() !== 5'b00000) begin
            errors++;
            $display("FAIL reset_mid_grant: got %b want %b", obs_vec(), 5'b00000);
        end
        rst_n = 1'b1;
        req = 4'b1111;
        tick();
        checks++;
        if (sel !== 2'd0 || sel_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_ptr_cleared: got sel=%0d vld=%b want sel=0 vld=1", sel, sel_valid);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) req = 4'($urandom_range(0, 15));
            done  = ($urandom_range(0, 11) == 0);
            rst_n = ($urandom_range(0, 249) != 0);
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                if (bad < 10)
                    $display("FAIL random_cycle%0d: got %b want %b", c, obs_vec(), exp_vec());
                bad++;
            end
        end
        rst_n = 1'b1; req = 4'b0000; done = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        m_grant = 0; m_sel = 0; m_ptr = 0; m_held = 0; m_to = 0;
        test_reset();
        test_single();
        test_rotate();
        test_scan_wrap();
        test_timeout();
        test_done_at_timeout();
        test_drop_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
